fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have these ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- pcjumpenable  in  3  redirect request: 0 none, 1 relative, 2 absolute, 3-7 ignored as none.
- pcchange  in  9  signed relative offset, in instruction words.
- pclocation  in  20  absolute target address.
- stall  in  1  decode cannot accept an instruction this cycle.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  20  instruction-memory word address.
- imem_ack  in  1  memory accepted the request and imem_data is valid, same cycle.
- imem_data  in  32  returned instruction word.
- instruction  out  32  instruction presented to decode.
- instruction_valid  out  1  instruction holds a live instruction.
- programcounter  out  20  next address to be fetched.
- previous_programcounter  out  20  address of the word currently on instruction; this is the link address for execute.

Function
REQ-002 The block SHALL be an FSM with states REQ, WAIT, DROP and HOLD.
REQ-003 In REQ and WAIT, imem_req SHALL be 1 and imem_addr SHALL equal programcounter.
REQ-004 The request is complete in the first cycle where imem_req=1 and imem_ack=1; there is no other completion condition.
REQ-005 imem_addr SHALL stay stable from request assertion through completion.
REQ-006 REQ->WAIT when imem_ack=0.
REQ-007 On completion in REQ or WAIT with no redirect, on the next edge:
- instruction <= imem_data;
- instruction_valid <= 1;
- previous_programcounter <= imem_addr;
- programcounter <= programcounter+1, modulo 2^20.
REQ-008 After a completion, the next state SHALL be HOLD if stall=1 and instruction_valid=1 in the completion cycle; otherwise it SHALL be REQ.
REQ-009 Decode consumes the output in any cycle with instruction_valid=1 and stall=0.
REQ-010 If the output is consumed and no completion occurs in that cycle, instruction_valid SHALL go to 0 on the next edge.
REQ-011 In HOLD:
- imem_req=0;
- instruction, instruction_valid, previous_programcounter and programcounter SHALL be held;
- HOLD->REQ on the first cycle with stall=0.
REQ-012 A redirect is pcjumpenable=1 or 2. It SHALL be sampled every cycle in every state, and it SHALL take priority over stall and over completion.
REQ-013 Relative target SHALL be previous_programcounter + sign-extended pcchange, modulo 2^20.
REQ-014 Absolute target SHALL be pclocation.
REQ-015 On a redirect edge:
- programcounter <= target;
- instruction_valid <= 0;
- instruction and previous_programcounter SHALL be held.
REQ-016 Next state after a redirect:
- from REQ with imem_ack=1, or from HOLD: REQ;
- from REQ with imem_ack=0, or from WAIT without ack: DROP;
- from WAIT with ack: REQ, and the acked data SHALL be discarded.
REQ-017 In DROP:
- imem_req SHALL be 1 and imem_addr SHALL be the stale address;
- on imem_ack the data SHALL be discarded and the state SHALL go to REQ;
- instruction_valid SHALL remain 0.
REQ-018 A further redirect while in DROP SHALL update programcounter only.
REQ-019 No instruction fetched before a redirect SHALL ever reach instruction_valid=1 after that redirect.
REQ-020 Minimum latency from request issue to instruction_valid is 1 cycle (ack in cycle N gives valid at N+1). Sustained throughput with ack=1 and stall=0 SHALL be 1 instruction per cycle.

Reset
REQ-021 While reset=1:
- state SHALL be REQ;
- imem_req SHALL be 0;
- programcounter, previous_programcounter, imem_addr, instruction and instruction_valid SHALL be 0.
REQ-022 In the first cycle after reset falls, imem_req SHALL be 1 with imem_addr=0.
REQ-023 Reset asserted in WAIT or DROP SHALL abandon the outstanding request with no discard state.
REQ-024 The memory SHALL NOT ack while imem_req=0.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset, then ack every cycle with data 0xA0000000+addr, stall=0 -> valid from cycle 2; instruction sequence A0000000, A0000001, ...; previous_programcounter 0,1,2,...
- previous_programcounter=0x00020, pcjumpenable=1, pcchange=0x1F6 (-10) -> next cycle programcounter=0x00016, instruction_valid=0, next imem_addr=0x00016.
- Absolute jump to 0x12345 while in WAIT, ack delayed 3 cycles -> imem_addr stays the old address until ack; that data is not presented; next request is at 0x12345.
- stall=1 for 4 cycles with instruction_valid=1 -> instruction and programcounter unchanged; imem_req=0 from the cycle after the completion; fetch resumes the cycle stall falls.
- Redirect and stall together; separately, pcjumpenable=3 -> redirect wins over stall; pcjumpenable=3 causes no change.
- programcounter=0xFFFFF fetch -> next programcounter=0x00000. Reset during DROP -> first post-reset request at address 0, no stale valid.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem read, redirect handling with
// stale-response discard, and a one-deep output register that holds under decode stall.
//
// state | meaning
// REQ   | issuing a request at programcounter
// WAIT  | request issued, waiting for imem_ack
// DROP  | redirected while a request was outstanding; discard its response
// HOLD  | output stalled with a live instruction; no request
module fetch_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  pcjumpenable,
  input  logic [8:0]  pcchange,
  input  logic [19:0] pclocation,
  input  logic        stall,
  output logic        imem_req,
  output logic [19:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction,
  output logic        instruction_valid,
  output logic [19:0] programcounter,
  output logic [19:0] previous_programcounter
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HOLD} state_t;

  state_t      state, state_nxt;
  logic [19:0] stale_addr;
  logic [19:0] target;
  logic        redirect;
  logic        fetching;
  logic        complete;
  logic        consume;

  assign redirect = (pcjumpenable == 3'd1) || (pcjumpenable == 3'd2);
  assign target   = (pcjumpenable == 3'd1)
                    ? previous_programcounter + {{11{pcchange[8]}}, pcchange}
                    : pclocation;
  assign fetching = (state == S_REQ) || (state == S_WAIT);
  assign complete = fetching && imem_req && imem_ack;
  assign consume  = instruction_valid && !stall;

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = programcounter;
    if (reset) begin
      imem_addr = '0;
    end else begin
      case (state)
        S_REQ, S_WAIT: imem_req = 1'b1;
        S_DROP: begin
          imem_req  = 1'b1;
          imem_addr = stale_addr;
        end
        default: imem_req = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ, S_WAIT: begin
        if (redirect)
          state_nxt = imem_ack ? S_REQ : S_DROP;
        else if (imem_ack)
          state_nxt = (stall && instruction_valid) ? S_HOLD : S_REQ;
        else
          state_nxt = S_WAIT;
      end
      S_DROP: if (imem_ack) state_nxt = S_REQ;
      S_HOLD: if (redirect || !stall) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                   <= S_REQ;
      stale_addr              <= '0;
      programcounter          <= '0;
      previous_programcounter <= '0;
      instruction             <= '0;
      instruction_valid       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (redirect) begin
        // The outstanding address must stay on the bus until the memory answers.
        if (fetching && !imem_ack) stale_addr <= programcounter;
        programcounter    <= target;
        instruction_valid <= 1'b0;
      end else if (complete) begin
        instruction             <= imem_data;
        instruction_valid       <= 1'b1;
        previous_programcounter <= imem_addr;
        programcounter          <= programcounter + 20'd1;
      end else if (consume) begin
        instruction_valid <= 1'b0;
      end
    end
  end

endmodule
